// File: rtl/cpu_eu_reg_bank.sv
// Execution-unit register bank: DEPTH x WIDTH registers with per-address load,
// +/-STEP count (wrap or saturate), a registered count-event flag and two async read ports.
module cpu_eu_reg_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] D_in,
  input  logic             cnt,
  input  logic             cnt_dn,
  input  logic [AW-1:0]    cnt_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] D_out_a,
  output logic [WIDTH-1:0] D_out_b,
  output logic             zero_a,
  output logic             wrap
);

  localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] rd_a, rd_b, cnt_base, cnt_res;
  logic [WIDTH:0]   sum, diff;
  logic             cnt_hit, cnt_ovf;

  // Address decode; out-of-range addresses match no register, so they read 0 and never count.
  always_comb begin
    rd_a     = '0;
    rd_b     = '0;
    cnt_base = D_in;
    cnt_hit  = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (rd_addr_a == AW'(r)) rd_a = regs_q[r];
      if (rd_addr_b == AW'(r)) rd_b = regs_q[r];
      if (cnt_addr == AW'(r)) begin
        cnt_hit = cnt;
        // A fused load+count on the same register counts from D_in.
        if (!(ld && ld_addr == cnt_addr)) cnt_base = regs_q[r];
      end
    end
  end

  always_comb begin
    sum  = {1'b0, cnt_base} + StepExt;
    diff = {1'b0, cnt_base} - StepExt;
    if (cnt_dn) begin
      cnt_ovf = diff[WIDTH];
      cnt_res = (SAT != 0 && cnt_ovf) ? '0 : diff[WIDTH-1:0];
    end else begin
      cnt_ovf = sum[WIDTH];
      cnt_res = (SAT != 0 && cnt_ovf) ? '1 : sum[WIDTH-1:0];
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (cnt_hit && cnt_addr == AW'(r)) begin
        regs_d[r] = cnt_res;
      end else if (ld && ld_addr == AW'(r)) begin
        regs_d[r] = D_in;
      end
    end
    wrap_d = cnt_hit & cnt_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  assign D_out_a = rd_a;
  assign D_out_b = rd_b;
  assign zero_a  = (rd_a == '0);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_cpu_eu_reg_bank.sv
// Bench for cpu_eu_reg_bank: two instances (wrap/STEP=1/DEPTH=8 and saturate/STEP=4/DEPTH=6)
// share stimulus and are compared against an integer-arithmetic model.
module tb_cpu_eu_reg_bank;

  logic        clk = 1'b0;
  logic        reset, ld, cnt, cnt_dn;
  logic [2:0]  ld_addr, cnt_addr, rd_addr_a, rd_addr_b;
  logic [15:0] D_in;
  logic [15:0] da [2];
  logic [15:0] db [2];
  logic        za [2];
  logic        wr [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state and per-instance configuration.
  int m   [2][8];
  int wm  [2];
  int dep [2] = '{8, 6};
  int stp [2] = '{1, 4};
  int sat [2] = '{0, 1};

  always #5 clk = ~clk;

  cpu_eu_reg_bank #(.WIDTH(16), .DEPTH(8), .AW(3), .STEP(1), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .ld(ld), .ld_addr(ld_addr), .D_in(D_in), .cnt(cnt),
    .cnt_dn(cnt_dn), .cnt_addr(cnt_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .D_out_a(da[0]), .D_out_b(db[0]), .zero_a(za[0]), .wrap(wr[0])
  );

  cpu_eu_reg_bank #(.WIDTH(16), .DEPTH(6), .AW(3), .STEP(4), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .ld(ld), .ld_addr(ld_addr), .D_in(D_in), .cnt(cnt),
    .cnt_dn(cnt_dn), .cnt_addr(cnt_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .D_out_a(da[1]), .D_out_b(db[1]), .zero_a(za[1]), .wrap(wr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int model_rd(input int b, input int addr);
    return (addr < dep[b]) ? m[b][addr] : 0;
  endfunction

  task automatic check_all();
    int ea;
    for (int b = 0; b < 2; b++) begin
      ea = model_rd(b, int'(rd_addr_a));
      check($sformatf("dut%0d.D_out_a", b), 32'(da[b]), 32'(ea));
      check($sformatf("dut%0d.D_out_b", b), 32'(db[b]), 32'(model_rd(b, int'(rd_addr_b))));
      check($sformatf("dut%0d.zero_a", b), 32'(za[b]), 32'(ea == 0));
      check($sformatf("dut%0d.wrap", b), 32'(wr[b]), 32'(wm[b]));
    end
  endtask

  // Next-state from the rules: plain signed arithmetic, then wrap or clamp.
  task automatic model_edge();
    int nm [2][8];
    int nw [2];
    int base, v;
    nm = m;
    for (int b = 0; b < 2; b++) begin
      nw[b] = 0;
      if (ld && int'(ld_addr) < dep[b]) nm[b][ld_addr] = int'(D_in);
      if (cnt && int'(cnt_addr) < dep[b]) begin
        base = (ld && ld_addr == cnt_addr) ? int'(D_in) : m[b][cnt_addr];
        v = cnt_dn ? base - stp[b] : base + stp[b];
        if (v < 0 || v > 65535) begin
          nw[b] = 1;
          if (sat[b] != 0) v = (v < 0) ? 0 : 65535;
          else v = v & 65535;
        end
        nm[b][cnt_addr] = v;
      end
      if (reset) begin
        for (int r = 0; r < 8; r++) nm[b][r] = 0;
        nw[b] = 0;
      end
    end
    m  = nm;
    wm = nw;
  endtask

  task automatic cycle(input bit chk, input bit rst, input bit l, input int la,
                       input logic [15:0] d, input bit c, input bit dn, input int ca,
                       input int ra, input int rb);
    reset = rst; ld = l; ld_addr = 3'(la); D_in = d;
    cnt = c; cnt_dn = dn; cnt_addr = 3'(ca); rd_addr_a = 3'(ra); rd_addr_b = 3'(rb);
    #1;
    if (chk) check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pool [5];

  initial begin
    pool = '{16'h0000, 16'hFFFF, 16'hFFFD, 16'h0003, 16'h8000};
    @(negedge clk);
    // Reset overrides a simultaneous load of reg2.
    cycle(0, 1, 1, 2, 16'hFFFF, 0, 0, 0, 2, 2);
    check("reset_rd_a", 32'(da[0]), 32'h0);
    check("reset_zero_a", 32'(za[0]), 32'h1);
    check("reset_wrap", 32'(wr[0]), 32'h0);
    // Load / readback, old value visible during the load cycle (model pre-check).
    cycle(1, 0, 1, 3, 16'h1234, 0, 0, 0, 3, 5);
    check("ld_reg3", 32'(da[0]), 32'h1234);
    cycle(1, 0, 1, 5, 16'hABCD, 0, 0, 0, 3, 5);
    check("ld_reg5", 32'(db[0]), 32'hABCD);
    // Fused load+count, then split load and count.
    cycle(1, 0, 1, 1, 16'h00FF, 1, 0, 1, 1, 2);
    check("fused_up", 32'(da[0]), 32'h0100);
    cycle(1, 0, 1, 2, 16'h0010, 1, 1, 1, 1, 2);
    check("split_dn_reg1", 32'(da[0]), 32'h00FF);
    check("split_ld_reg2", 32'(db[0]), 32'h0010);
    // Modulo wrap in both directions, then idle clears the pulse.
    cycle(1, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0);
    check("wrap_up_val", 32'(da[0]), 32'h0);
    check("wrap_up_flag", 32'(wr[0]), 32'h1);
    check("wrap_up_zero", 32'(za[0]), 32'h1);
    cycle(1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0);
    check("wrap_dn_val", 32'(da[0]), 32'hFFFF);
    check("wrap_dn_flag", 32'(wr[0]), 32'h1);
    cycle(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    check("wrap_idle", 32'(wr[0]), 32'h0);
    // Saturate instance, STEP=4.
    cycle(1, 0, 1, 4, 16'hFFFD, 0, 0, 0, 4, 4);
    cycle(1, 0, 0, 0, 16'h0000, 1, 0, 4, 4, 4);
    check("sat_up_val", 32'(da[1]), 32'hFFFF);
    check("sat_up_flag", 32'(wr[1]), 32'h1);
    cycle(1, 0, 1, 4, 16'h0004, 0, 0, 0, 4, 4);
    cycle(1, 0, 0, 0, 16'h0000, 1, 1, 4, 4, 4);
    check("sat_exact_val", 32'(da[1]), 32'h0);
    check("sat_exact_flag", 32'(wr[1]), 32'h0);
    cycle(1, 0, 0, 0, 16'h0000, 1, 1, 4, 4, 4);
    check("sat_dn_val", 32'(da[1]), 32'h0);
    check("sat_dn_flag", 32'(wr[1]), 32'h1);
    // Out-of-range on the DEPTH=6 instance.
    cycle(1, 0, 1, 7, 16'h5555, 1, 0, 6, 7, 4);
    check("oor_rd", 32'(da[1]), 32'h0);
    check("oor_zero", 32'(za[1]), 32'h1);
    check("oor_wrap", 32'(wr[1]), 32'h0);
    check("oor_reg4_held", 32'(db[1]), 32'h0);
    // Randomised traffic with boundary-biased data and occasional reset.
    for (int i = 0; i < 600; i++) begin
      cycle(1, ($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : 16'($urandom),
            1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    cycle(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
